buffer_write_arbiter: RTL

BUFFER_WRITE_ARBITER -- requirements
Module: buffer_write_arbiter

---
 rtl/buffer_arb_pkg.sv | 7 +
 rtl/buffer_write_arbiter_rr_arbiter.sv | 26 ++
 rtl/buffer_write_arbiter.sv | 74 +++++++
 3 files changed

// File: rtl/buffer_arb_pkg.sv
// buffer_arb_pkg: shared FSM state type and default parameters for the buffer write arbiter
package buffer_arb_pkg;
    typedef enum logic {IDLE, BURST} state_t;
    localparam int NUM_REQ_DEF   = 4;
    localparam int WORD_SIZE_DEF = 32;
    localparam int MAX_BURST_DEF = 16;
endpackage

// File: rtl/buffer_write_arbiter_rr_arbiter.sv
// rr_arbiter: grants the first requester at or after ptr, searching upward modulo NUM_REQ
module rr_arbiter
    import buffer_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    localparam int TAG_W = $clog2(NUM_REQ);
    logic found;
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
                idx = TAG_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/buffer_write_arbiter.sv
// buffer_write_arbiter: round-robin arbitration of NUM_REQ burst writers onto one buffer write port
module buffer_write_arbiter
    import buffer_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*WORD_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         buf_full,
    output logic                         buf_wr,
    output logic [WORD_SIZE-1:0]         buf_data,
    output logic [$clog2(NUM_REQ)-1:0]   buf_tag,
    output logic                         burst_abort
);
    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    state_t state, state_next;
    logic [TAG_W-1:0] rr_ptr, lock, arb_idx, gnt;
    logic [NUM_REQ-1:0] arb_grant;
    logic [CNT_W-1:0] burst_cnt, cnt_next;
    logic open, xfer, last, abort, done;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // The arbiter reports index 0 with no request, so xfer stays low then
    assign open     = !rst && !buf_full;
    assign gnt      = state == BURST ? lock : arb_idx;
    assign xfer     = open && req_valid[gnt];
    assign last     = req_last[gnt];
    assign cnt_next = state == BURST ? burst_cnt + 1'b1 : CNT_W'(1);
    assign abort    = xfer && !last && cnt_next == CNT_W'(MAX_BURST);
    assign done     = xfer && (last || abort);

    always_ff @(posedge clk) state <= rst ? IDLE : state_next;

    always_comb state_next = !xfer ? state : done ? IDLE : BURST;

    always_comb req_ready = !open ? '0 : state == IDLE ? arb_grant :
                            req_valid[lock] ? NUM_REQ'(1) << lock : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            lock        <= '0;
            burst_cnt   <= '0;
            buf_wr      <= 1'b0;
            buf_data    <= '0;
            buf_tag     <= '0;
            burst_abort <= 1'b0;
        end else begin
            buf_wr      <= xfer;
            burst_abort <= abort;
            if (xfer) begin
                buf_data  <= req_data[int'(gnt)*WORD_SIZE +: WORD_SIZE];
                buf_tag   <= gnt;
                lock      <= gnt;
                burst_cnt <= done ? '0 : cnt_next;
            end
            if (done)
                rr_ptr <= gnt == TAG_W'(NUM_REQ - 1) ? '0 : gnt + 1'b1;
        end
    end
endmodule
